// File: rtl/smul_pkg.sv
// -----------------------------------------------------------------------------
// smul_pkg
//   Shared types and defaults for the signed-multiply sequencer.
//   - smul_state_t  : sequencer FSM state encoding
//   - SMUL_*        : default operand widths and watchdog limit
//   - smul_cnt_width: width of the WAIT-state watchdog counter
// -----------------------------------------------------------------------------
package smul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } smul_state_t;

    localparam int SMUL_X_WIDTH  = 8;
    localparam int SMUL_Y_WIDTH  = 8;
    localparam int SMUL_WAIT_MAX = 4;

    // Counter must be able to represent WAIT_MAX itself.
    function automatic int smul_cnt_width(input int wait_max);
        return $clog2(wait_max + 1);
    endfunction

endpackage

// File: rtl/smul_abs.sv
// -----------------------------------------------------------------------------
// smul_abs
//   Combinational two's-complement conditional negate.
//   With ext_en=0 it produces the magnitude of v (negates when v is negative);
//   with ext_en=1 it negates when ext_neg=1, which is how the sequencer
//   restores the sign of the unsigned product.
// Ports
//   v       in  W  operand
//   ext_en  in  1  1: negate decision comes from ext_neg, 0: from v[W-1]
//   ext_neg in  1  external negate request (used only when ext_en=1)
//   mag     out W  v or -v (W-bit two's complement)
//   sign    out 1  sign bit of v
// -----------------------------------------------------------------------------
module smul_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] v,
    input  logic         ext_en,
    input  logic         ext_neg,
    output logic [W-1:0] mag,
    output logic         sign
);

    logic do_neg;

    assign sign   = v[W-1];
    assign do_neg = ext_en ? ext_neg : v[W-1];

    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign mag = do_neg ? (~v + W'(1)) : v;

endmodule

// File: rtl/smul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// smul_seq_ctrl
//   Sequencer between a signed operand source and an unsigned multiplier core.
//   Takes signed X/Y on an input handshake, hands |X|/|Y| to the core with a
//   one-cycle Mul strobe, waits for Done (with a watchdog), restores the sign
//   and presents Z on an output handshake.
// Ports
//   Clk       in   1        clock, rising edge
//   reset_n   in   1        asynchronous active-low reset
//   in_valid  in   1        X/Y valid
//   in_ready  out  1        operands accepted (IDLE only)
//   X, Y      in   X/Y_W    signed operands
//   Mul       out  1        start strobe to core
//   X_pos     out  X_WIDTH  |X| to core
//   Y_pos     out  Y_WIDTH  |Y| to core
//   Done      in   1        core completion (sticky in core)
//   Z_pos     in   Z_WIDTH  core unsigned product
//   Z         out  Z_WIDTH  signed product
//   out_valid out  1        Z valid
//   out_ready in   1        consumer accepts Z
//   err_tmo   out  1        sticky watchdog error, cleared only by reset
// -----------------------------------------------------------------------------
module smul_seq_ctrl
    import smul_pkg::*;
#(
    parameter  int X_WIDTH  = SMUL_X_WIDTH,
    parameter  int Y_WIDTH  = SMUL_Y_WIDTH,
    parameter  int WAIT_MAX = SMUL_WAIT_MAX,
    localparam int Z_WIDTH  = X_WIDTH + Y_WIDTH
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_WIDTH-1:0] X,
    input  logic [Y_WIDTH-1:0] Y,
    output logic               Mul,
    output logic [X_WIDTH-1:0] X_pos,
    output logic [Y_WIDTH-1:0] Y_pos,
    input  logic               Done,
    input  logic [Z_WIDTH-1:0] Z_pos,
    output logic [Z_WIDTH-1:0] Z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err_tmo
);

    localparam int                   CNT_WIDTH = smul_cnt_width(WAIT_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(WAIT_MAX - 1);

    smul_state_t          state_q, state_d;
    logic [X_WIDTH-1:0]   x_pos_q;
    logic [Y_WIDTH-1:0]   y_pos_q;
    logic                 neg_q;
    logic [Z_WIDTH-1:0]   z_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 load_ops, load_z, tmo_hit, cnt_clr, cnt_inc;

    logic [X_WIDTH-1:0]   x_mag;
    logic [Y_WIDTH-1:0]   y_mag;
    logic                 x_sign, y_sign;
    logic [Z_WIDTH-1:0]   z_signed;
    logic                 z_sign_unused;

    // Operand magnitudes and sign.
    smul_abs #(.W(X_WIDTH)) u_abs_x (
        .v       (X),
        .ext_en  (1'b0),
        .ext_neg (1'b0),
        .mag     (x_mag),
        .sign    (x_sign)
    );

    smul_abs #(.W(Y_WIDTH)) u_abs_y (
        .v       (Y),
        .ext_en  (1'b0),
        .ext_neg (1'b0),
        .mag     (y_mag),
        .sign    (y_sign)
    );

    // Sign restore: negate the core product when the operand signs differed.
    // A zero product negates to zero, so no sign artefact is possible.
    smul_abs #(.W(Z_WIDTH)) u_abs_z (
        .v       (Z_pos),
        .ext_en  (1'b1),
        .ext_neg (neg_q),
        .mag     (z_signed),
        .sign    (z_sign_unused)
    );

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        load_ops = 1'b0;
        load_z   = 1'b0;
        tmo_hit  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_ops = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                // Done is sticky in the core but was cleared on the ISSUE
                // edge, so any Done seen here belongs to this operation.
                if (Done) begin
                    load_z  = 1'b1;
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    load_z  = 1'b1;
                    tmo_hit = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            OUT: begin
                // Always return through IDLE; no accept on the exit cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, result, watchdog and error registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            neg_q   <= 1'b0;
            z_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // X_pos/Y_pos hold from ISSUE through WAIT for the core.
            if (load_ops) begin
                x_pos_q <= x_mag;
                y_pos_q <= y_mag;
                neg_q   <= x_sign ^ y_sign;
            end

            if (load_z) begin
                z_q <= tmo_hit ? '0 : z_signed;
            end

            if (tmo_hit) begin
                err_q <= 1'b1;
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign Mul       = (state_q == ISSUE);
    assign out_valid = (state_q == OUT);
    assign X_pos     = x_pos_q;
    assign Y_pos     = y_pos_q;
    assign Z         = z_q;
    assign err_tmo   = err_q;

endmodule

// File: tb/tb_smul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_smul_seq_ctrl
//   Bench for smul_seq_ctrl with a behavioural stand-in for the unsigned
//   multiplier core: on Mul it clears Done and computes, one cycle later it
//   presents Z_pos and raises a sticky Done (or leaves Done low when stuck).
//   Expected products are pushed to a queue when operands are driven and
//   popped when the DUT presents a result.
// -----------------------------------------------------------------------------
module tb_smul_seq_ctrl;

    localparam int XW       = 8;
    localparam int YW       = 8;
    localparam int ZW       = XW + YW;
    localparam int WAIT_MAX = 4;

    logic          Clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] X = '0;
    logic [YW-1:0] Y = '0;
    logic          Mul;
    logic [XW-1:0] X_pos;
    logic [YW-1:0] Y_pos;
    logic          Done;
    logic [ZW-1:0] Z_pos;
    logic [ZW-1:0] Z;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_tmo;

    int            n_vec = 0;
    int            n_err = 0;
    logic [ZW-1:0] exp_q[$];

    always #5 Clk = ~Clk;

    smul_seq_ctrl #(
        .X_WIDTH  (XW),
        .Y_WIDTH  (YW),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Mul       (Mul),
        .X_pos     (X_pos),
        .Y_pos     (Y_pos),
        .Done      (Done),
        .Z_pos     (Z_pos),
        .Z         (Z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_tmo   (err_tmo)
    );

    // Core stand-in; its active-high reset is ~reset_n.
    logic          core_stuck = 1'b0;
    logic          core_busy;
    logic [ZW-1:0] core_calc;

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            Done      <= 1'b0;
            core_busy <= 1'b0;
            core_calc <= '0;
            Z_pos     <= '0;
        end else if (Mul) begin
            Done      <= 1'b0;
            core_busy <= 1'b1;
            core_calc <= ZW'(X_pos) * ZW'(Y_pos);
        end else if (core_busy) begin
            core_busy <= 1'b0;
            Done      <= ~core_stuck;
            Z_pos     <= core_calc;
        end
    end

    function automatic logic [ZW-1:0] ref_mul(input logic signed [XW-1:0] a,
                                              input logic signed [YW-1:0] b);
        logic signed [ZW-1:0] p;
        p = a * b;
        return p;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge after
    // the accept edge (DUT in ISSUE).
    task automatic send_op(input logic [XW-1:0] x, input logic [YW-1:0] y,
                           input logic tmo);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_wait_ready: in_ready=%b required 1 after %0d cycles", in_ready, k);
        end
        X        = x;
        Y        = y;
        in_valid = 1'b1;
        exp_q.push_back(tmo ? '0 : ref_mul(x, y));
        @(negedge Clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; cycles = negedges waited.
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge Clk);
            cycles++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_out: out_valid=%b required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic pop_exp(output logic [ZW-1:0] e);
        if (exp_q.size() == 0) e = 'x;
        else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if (in_ready !== 1'b1 || Mul !== 1'b0 || out_valid !== 1'b0 || err_tmo !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b Mul=%b out_valid=%b err_tmo=%b required 1 0 0 0",
                     in_ready, Mul, out_valid, err_tmo);
        end
        n_vec++;
        if (Z !== '0 || X_pos !== '0 || Y_pos !== '0) begin
            n_err++;
            $display("FAIL reset_data: Z=%h X_pos=%h Y_pos=%h required 0 0 0", Z, X_pos, Y_pos);
        end
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        int            c;
        logic [ZW-1:0] e;
        send_op(8'd5, 8'hFD, 1'b0);
        n_vec++;
        if (Mul !== 1'b1 || X_pos !== 8'd5 || Y_pos !== 8'd3) begin
            n_err++;
            $display("FAIL basic_issue: Mul=%b X_pos=%h Y_pos=%h required 1 05 03", Mul, X_pos, Y_pos);
        end
        @(negedge Clk);
        n_vec++;
        if (Mul !== 1'b0 || out_valid !== 1'b0 || X_pos !== 8'd5 || Y_pos !== 8'd3) begin
            n_err++;
            $display("FAIL basic_wait: Mul=%b out_valid=%b X_pos=%h Y_pos=%h required 0 0 05 03",
                     Mul, out_valid, X_pos, Y_pos);
        end
        wait_out(c);
        n_vec++;
        if (c !== 2) begin
            n_err++;
            $display("FAIL basic_latency: out_valid after %0d edges required 3", c + 1);
        end
        pop_exp(e);
        n_vec++;
        if (Z !== e || Z !== 16'hFFF1) begin
            n_err++;
            $display("FAIL basic_z: Z=%h required %h", Z, e);
        end
        @(negedge Clk);
    endtask

    task automatic test_most_negative();
        int            c;
        logic [ZW-1:0] e;
        send_op(8'h80, 8'h80, 1'b0);
        n_vec++;
        if (X_pos !== 8'h80 || Y_pos !== 8'h80) begin
            n_err++;
            $display("FAIL minneg_mag: X_pos=%h Y_pos=%h required 80 80", X_pos, Y_pos);
        end
        wait_out(c);
        pop_exp(e);
        n_vec++;
        if (Z !== e || Z !== 16'h4000) begin
            n_err++;
            $display("FAIL minneg_z: Z=%h required %h", Z, e);
        end
        @(negedge Clk);
    endtask

    task automatic test_zero_back_to_back();
        int            c;
        logic [ZW-1:0] e;
        send_op(8'd0, 8'hF9, 1'b0);
        wait_out(c);
        pop_exp(e);
        n_vec++;
        if (Z !== e || Z !== 16'h0000) begin
            n_err++;
            $display("FAIL zero_z: Z=%h required %h", Z, e);
        end
        // Present the next op while OUT is exiting; it must wait for IDLE.
        X        = 8'hFF;
        Y        = 8'h01;
        in_valid = 1'b1;
        exp_q.push_back(ref_mul(8'hFF, 8'h01));
        @(negedge Clk);
        n_vec++;
        if (in_ready !== 1'b1 || Mul !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_visit: in_ready=%b Mul=%b required 1 0", in_ready, Mul);
        end
        @(negedge Clk);
        in_valid = 1'b0;
        n_vec++;
        if (Mul !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_issue: Mul=%b required 1", Mul);
        end
        wait_out(c);
        pop_exp(e);
        n_vec++;
        if (Z !== e || Z !== 16'hFFFF) begin
            n_err++;
            $display("FAIL b2b_z: Z=%h required %h", Z, e);
        end
        @(negedge Clk);
    endtask

    task automatic test_backpressure();
        int            c;
        logic [ZW-1:0] e;
        logic [ZW-1:0] z0;
        out_ready = 1'b0;
        send_op(8'hF7, 8'h0B, 1'b0);
        wait_out(c);
        z0 = Z;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_vec++;
            if (out_valid !== 1'b1 || Z !== z0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: out_valid=%b Z=%h in_ready=%b required 1 %h 0",
                         i, out_valid, Z, in_ready, z0);
            end
        end
        pop_exp(e);
        n_vec++;
        if (Z !== e) begin
            n_err++;
            $display("FAIL bp_z: Z=%h required %h", Z, e);
        end
        out_ready = 1'b1;
        @(negedge Clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_timeout();
        int            c;
        logic [ZW-1:0] e;
        core_stuck = 1'b1;
        send_op(8'd3, 8'd4, 1'b1);
        n_vec++;
        if (err_tmo !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_pre: err_tmo=%b required 0", err_tmo);
        end
        wait_out(c);
        n_vec++;
        if (c !== WAIT_MAX + 1 || err_tmo !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_flag: out after %0d cycles err_tmo=%b required %0d 1",
                     c, err_tmo, WAIT_MAX + 1);
        end
        pop_exp(e);
        n_vec++;
        if (Z !== e) begin
            n_err++;
            $display("FAIL tmo_z: Z=%h required %h", Z, e);
        end
        @(negedge Clk);
        core_stuck = 1'b0;
        send_op(8'hFA, 8'd7, 1'b0);
        wait_out(c);
        pop_exp(e);
        n_vec++;
        if (Z !== e || err_tmo !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_recover: Z=%h err_tmo=%b required %h 1", Z, err_tmo, e);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_op();
        int seen_valid = 0;
        // Reset during WAIT, with a non-zero Z held and err_tmo set.
        send_op(8'd2, 8'd3, 1'b0);
        @(negedge Clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (Mul !== 1'b0 || out_valid !== 1'b0 || Z !== '0 || err_tmo !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_wait: Mul=%b out_valid=%b Z=%h err_tmo=%b in_ready=%b required 0 0 0 0 1",
                     Mul, out_valid, Z, err_tmo, in_ready);
        end
        exp_q.delete();
        @(negedge Clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (out_valid) seen_valid++;
        end
        n_vec++;
        if (seen_valid != 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_discard: out_valid cycles=%0d in_ready=%b required 0 1", seen_valid, in_ready);
        end
        // Reset during ISSUE: Mul must drop at once.
        send_op(8'd9, 8'd9, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (Mul !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_issue: Mul=%b in_ready=%b required 0 1", Mul, in_ready);
        end
        exp_q.delete();
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_random();
        int            c;
        logic [ZW-1:0] e;
        logic [XW-1:0] rx;
        logic [YW-1:0] ry;
        for (int i = 0; i < 10; i++) begin
            rx = XW'($urandom_range(0, 255));
            ry = YW'($urandom_range(0, 255));
            send_op(rx, ry, 1'b0);
            wait_out(c);
            pop_exp(e);
            n_vec++;
            if (Z !== e || c !== 3) begin
                n_err++;
                $display("FAIL rand[%0d]: X=%h Y=%h Z=%h wait=%0d required %h 3", i, rx, ry, Z, c, e);
            end
            @(negedge Clk);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d results outstanding required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_most_negative();
        test_zero_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish within 200000 time units");
        $fatal(1, "simulation time limit reached");
    end

endmodule
